pipe_ctrl: RTL

Central stall/flush controller for the 5-stage MIPS pipeline. It sequences the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC through per-stage enable and flush strobes. It arbitrates three hazard sources:

- multi-cycle data-memory accesses (req/ack handshake with a watchdog);
- load-use data hazards;
- taken branches resolved in EX.

It sits beside the datapath and drives the enable/flush pins of every pipeline register.

---
 rtl/pipe_ctrl_pkg.sv | 36 +++
 rtl/pipe_ctrl_if.sv | 43 ++++
 rtl/pipe_ctrl_hazard_detect.sv | 26 ++
 rtl/pipe_ctrl.sv | 125 ++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
// Pure declarations: no logic, no latency.
package pipe_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_RUN      = 2'd0;
    localparam state_t ST_MEM_WAIT = 2'd1;
    localparam state_t ST_ERR      = 2'd2;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic id_ex_en;
        logic ex_mem_en;
        logic mem_wb_en;
        logic if_id_flush;
        logic id_ex_flush;
    } strobe_t;

    // Every register enabled (or frozen), no bubbles injected.
    function automatic strobe_t strobes_uniform(input logic en);
        strobe_t s;
        s.pc_en       = en;
        s.if_id_en    = en;
        s.id_ex_en    = en;
        s.ex_mem_en   = en;
        s.mem_wb_en   = en;
        s.if_id_flush = 1'b0;
        s.id_ex_flush = 1'b0;
        return s;
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Datapath <-> stall controller signal bundle; master is the datapath side.
// Pure wiring: zero latency.
interface pipe_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rs;
    logic             id_uses_rt;
    logic             ex_wreg;
    logic             ex_m2reg;
    logic [4:0]       ex_reg_addr;
    logic             ex_branch_taken;
    logic             mem_req;
    logic             dmem_ack;
    logic             dmem_req;
    logic             pc_en;
    logic             if_id_en;
    logic             id_ex_en;
    logic             ex_mem_en;
    logic             mem_wb_en;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output id_rs, id_rt, id_uses_rs, id_uses_rt,
        output ex_wreg, ex_m2reg, ex_reg_addr, ex_branch_taken,
        output mem_req, dmem_ack,
        input  dmem_req, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
        input  if_id_flush, id_ex_flush, mem_err, stall_cnt
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rs, id_uses_rt,
        input  ex_wreg, ex_m2reg, ex_reg_addr, ex_branch_taken,
        input  mem_req, dmem_ack,
        output dmem_req, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
        output if_id_flush, id_ex_flush, mem_err, stall_cnt
    );

endinterface

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use hazard compare between the load in EX and the operands of ID.
// Purely combinational; no backpressure of its own.
module hazard_detect
    import pipe_pkg::*;
(
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rs,
    input  logic       id_uses_rt,
    input  logic       ex_wreg,
    input  logic       ex_m2reg,
    input  logic [4:0] ex_reg_addr,
    output logic       lu_hazard
);

    logic ex_load_vld;
    logic rs_match;
    logic rt_match;

    // $zero is never a real producer, so a load into it cannot create a hazard.
    assign ex_load_vld = ex_m2reg & ex_wreg & (ex_reg_addr != REG_ZERO);
    assign rs_match    = id_uses_rs & (id_rs == ex_reg_addr);
    assign rt_match    = id_uses_rt & (id_rt == ex_reg_addr);
    assign lu_hazard   = ex_load_vld & (rs_match | rt_match);

endmodule

// File: rtl/pipe_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: memory wait, branch squash, load-use bubble.
// Strobes are combinational (zero latency); an unacked data access freezes the whole pipe.
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic        clk,
    input  logic        rst,
    pipe_ctrl_if.slave  bus
);

    localparam int WC_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    state_t           state_q, state_d;
    logic [WC_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic             mem_err_q, mem_err_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic    lu_hazard;
    logic    mem_stall;
    logic    dmem_req;
    strobe_t st;

    hazard_detect u_hazard_detect (
        .id_rs       (bus.id_rs),
        .id_rt       (bus.id_rt),
        .id_uses_rs  (bus.id_uses_rs),
        .id_uses_rt  (bus.id_uses_rt),
        .ex_wreg     (bus.ex_wreg),
        .ex_m2reg    (bus.ex_m2reg),
        .ex_reg_addr (bus.ex_reg_addr),
        .lu_hazard   (lu_hazard)
    );

    assign mem_stall = (state_q != ST_ERR) & bus.mem_req & ~bus.dmem_ack;

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        mem_err_d  = mem_err_q;
        unique case (state_q)
            ST_RUN: begin
                if (mem_stall) begin
                    state_d    = ST_MEM_WAIT;
                    wait_cnt_d = '0;
                end
            end
            ST_MEM_WAIT: begin
                if (mem_stall) begin
                    if (wait_cnt_q == WC_W'(TIMEOUT - 1)) begin
                        state_d   = ST_ERR;
                        mem_err_d = 1'b1;
                    end else begin
                        wait_cnt_d = wait_cnt_q + WC_W'(1);
                    end
                end else begin
                    // Ack, or a dropped request, both release the wait.
                    state_d = ST_RUN;
                end
            end
            ST_ERR: begin
                state_d = ST_ERR;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_comb begin
        st       = strobes_uniform(1'b1);
        dmem_req = bus.mem_req & (state_q != ST_ERR);
        if (rst) begin
            st       = strobes_uniform(1'b1);
            dmem_req = 1'b0;
        end else if (state_q == ST_ERR) begin
            st = strobes_uniform(1'b0);
        end else if (mem_stall) begin
            st = strobes_uniform(1'b0);
        end else if (bus.ex_branch_taken) begin
            // The ID instruction is squashed, so any load-use hazard is moot.
            st.if_id_flush = 1'b1;
            st.id_ex_flush = 1'b1;
        end else if (lu_hazard) begin
            st.pc_en       = 1'b0;
            st.if_id_en    = 1'b0;
            st.id_ex_flush = 1'b1;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!st.pc_en && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            wait_cnt_q  <= '0;
            mem_err_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_err_q   <= mem_err_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.dmem_req    = dmem_req;
    assign bus.pc_en       = st.pc_en;
    assign bus.if_id_en    = st.if_id_en;
    assign bus.id_ex_en    = st.id_ex_en;
    assign bus.ex_mem_en   = st.ex_mem_en;
    assign bus.mem_wb_en   = st.mem_wb_en;
    assign bus.if_id_flush = st.if_id_flush;
    assign bus.id_ex_flush = st.id_ex_flush;
    assign bus.mem_err     = mem_err_q;
    assign bus.stall_cnt   = stall_cnt_q;

endmodule
